spi_burst_master: RTL and testbench
===================================

SPI_BURST_MASTER -- requirements
Module: spi_burst_master

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8, bits per word (range 4..32).
- NUM_SS, default 4, number of slave-select lines (range 1..8).
- DIV_WIDTH, default 8, width of the clock-divider setting.
REQ-002 Ports SHALL be:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- lsb_first  in  1  bit order.
- clk_div  in  DIV_WIDTH  half-period = clk_div+1 clk cycles.
- ss_sel  in  SSW (= max(1, clog2(NUM_SS)))  target slave.
- tx_data  in  DATA_WIDTH  word to send.
- tx_last  in  1  final word of burst.
- tx_valid  in  1  word offered.
- tx_ready  out  1  word accepted when tx_valid && tx_ready.
- rx_data  out  DATA_WIDTH  received word.
- rx_valid  out  1  rx_data held until rx_ready.
- rx_ready  in  1  consumer accepts.
- busy  out  1  high in every state except IDLE.
- sclk  out  1  serial clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- ss_n  out  NUM_SS  active-low one-hot select.

Function
REQ-003 The FSM SHALL have states IDLE, SETUP, SHIFT, GAP and HOLD.
REQ-004 IDLE:
- tx_ready = !rx_valid.
- On accept: latch cpol, cpha, lsb_first, clk_div and ss_sel for the whole burst; load the shift register; go to SETUP.
REQ-005 SETUP SHALL drive ss_n[ss_sel] low and last clk_div+1 cycles, then go to SHIFT.
- cpha=0: the first bit is on mosi on entry to SETUP.
REQ-006 SHIFT SHALL generate 2*DATA_WIDTH half-periods, each clk_div+1 cycles, toggling sclk at each half-period end.
- Bit sampling: leading edges when cpha=0, trailing edges when cpha=1.
- Other edges shift mosi; for cpha=1 the first bit is shifted on the first leading edge.
REQ-007 A word SHALL complete after the final edge:
- rx_data is loaded and rx_valid set in the same clk cycle.
- sclk equals the latched cpol.
REQ-008 After a word, the FSM SHALL go to GAP if the word was not tx_last, and to HOLD if it was tx_last.
REQ-009 GAP:
- ss_n stays asserted; tx_ready = !rx_valid.
- On accept: reload, and go to SHIFT after one half-period.
- With no accept: wait indefinitely.
REQ-010 HOLD SHALL keep ss_n asserted for clk_div+1 cycles, then deassert all ss_n and go to IDLE.
REQ-011 The word SHALL be transmitted MSB-first when lsb_first=0 and LSB-first when lsb_first=1.
- rx_data SHALL be assembled in the same order.
REQ-012 The engine SHALL never start a word while rx_valid is high (no rx overrun possible).
REQ-013 ss_sel values >= NUM_SS SHALL select no line (all ss_n high); timing is unchanged.
REQ-014 Input changes of cpol, cpha, lsb_first, clk_div and ss_sel mid-burst SHALL have no effect until the next IDLE accept.
REQ-015 When rx_valid && rx_ready, rx_valid SHALL clear on the next edge.
- When a new word completes in that same cycle, rx_valid SHALL stay high with the new data.
REQ-016 With clk_div=0, SHIFT SHALL last exactly 2*DATA_WIDTH clk cycles.

Reset
REQ-017 On rst_n low, asynchronously:
- state = IDLE.
- ss_n all 1.
- sclk = 0 (cpol applied from the first IDLE cycle after reset).
- mosi = 0; rx_data = 0; rx_valid = 0; busy = 0.
- tx_ready = 1 from the first cycle after release.
REQ-018 Reset mid-burst SHALL abort immediately and discard partial rx data.

Structure
REQ-019 State encoding, the default parameter values and the mode constants SHALL be placed in shared package spi_pkg.
REQ-020 The half-period timer (load clk_div, pulse on expiry) SHALL be one sub-module: spi_sclk_gen.

Verification
REQ-021 Mode 0, DATA_WIDTH=8, clk_div=0, tx 0xA5 with tx_last, miso loopback:
- rx_data = 0xA5.
- ss_n[0] low for 1+16+1 cycles.
- Exactly 8 rising sclk edges.
REQ-022 Mode 3 with lsb_first=1, clk_div=3, slave returns 0x3C:
- rx_data = 0x3C.
- Each sclk half-period lasts 4 cycles.
- sclk idles high.
REQ-023 Burst of 3 words (0x11, 0x22, 0x33, last on the third), ss_sel=2:
- ss_n = 4'b1011 continuously across both GAPs.
- Three rx_valid pulses.
REQ-024 Hold rx_ready=0 after the first word of a burst:
- tx_ready stays 0 in GAP and no sclk toggles.
- After rx_ready=1, the burst resumes and no data is lost.
REQ-025 Assert rst_n low after the 4th bit:
- ss_n = all 1, sclk = 0, rx_valid = 0 within the same cycle.
- The next transfer completes correctly.
REQ-026 Change cpol and clk_div mid-burst:
- The burst still uses the latched values.
- The next burst uses the new values.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst master: FSM encoding, parameter
// defaults and the SPI mode constants (bit 1 = CPOL, bit 0 = CPHA).
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_HOLD
  } spi_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_SS     = 4;
  localparam int DEF_DIV_WIDTH  = 8;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer: restarts from i_div on i_load, and while enabled pulses
// o_tick every i_div+1 cycles, reloading itself on each expiry.
module spi_sclk_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_div;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? i_div : r_cnt - 1'b1;
    end
  end

  assign o_tick = i_en && !i_load && (r_cnt == '0);

endmodule

// File: rtl/spi_burst_master.sv
// SPI master that moves bursts of words under a single slave select, with
// per-burst latched mode, bit order, clock divider and target slave.
module spi_burst_master
  import spi_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_SS     = DEF_NUM_SS,
  parameter  int DIV_WIDTH  = DEF_DIV_WIDTH,
  localparam int SSW        = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [SSW-1:0]        ss_sel,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_last,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SS-1:0]     ss_n
);

  localparam int HW = $clog2(2 * DATA_WIDTH);

  spi_state_t r_state, w_next;

  logic                  r_cpol, r_cpha, r_lsb, r_last, r_armed;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [SSW-1:0]        r_ss;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_rx_data;
  logic                  r_rx_valid, r_sclk, r_mosi;
  logic [HW-1:0]         r_hcnt;

  logic                  w_idle, w_accept, w_tick, w_tmr_en;
  logic                  w_cpha, w_lsb;
  logic [DIV_WIDTH-1:0]  w_div;
  logic                  w_edge, w_last_half, w_sample, w_shift, w_done;
  logic [DATA_WIDTH-1:0] w_rx_next;

  function automatic logic [DATA_WIDTH-1:0] shift_word(
    input logic [DATA_WIDTH-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  function automatic logic out_bit(input logic [DATA_WIDTH-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_WIDTH-1];
  endfunction

  // Config inputs are only looked at in IDLE; afterwards the latched copies rule.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = tx_valid && tx_ready;
  assign w_cpha   = w_idle ? cpha : r_cpha;
  assign w_lsb    = w_idle ? lsb_first : r_lsb;
  assign w_div    = w_idle ? clk_div : r_div;

  assign w_tmr_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT) ||
                    (r_state == ST_HOLD)  || ((r_state == ST_GAP) && r_armed);

  spi_sclk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_sclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_en   (w_tmr_en),
    .i_div  (w_div),
    .o_tick (w_tick)
  );

  // Even half-period ends are leading edges, odd ones trailing edges.
  assign w_edge      = (r_state == ST_SHIFT) && w_tick;
  assign w_last_half = (r_hcnt == HW'(2 * DATA_WIDTH - 1));
  assign w_sample    = w_edge && (r_cpha ? r_hcnt[0] : !r_hcnt[0]);
  assign w_shift     = w_edge && (r_cpha ? !r_hcnt[0] : r_hcnt[0]);
  assign w_done      = w_edge && w_last_half;
  assign w_rx_next   = r_lsb ? {miso, r_rx[DATA_WIDTH-1:1]}
                             : {r_rx[DATA_WIDTH-2:0], miso};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    tx_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        tx_ready = !r_rx_valid;
        if (w_accept) w_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (w_tick) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_done) w_next = r_last ? ST_HOLD : ST_GAP;
      end
      ST_GAP: begin
        tx_ready = !r_rx_valid && !r_armed;
        if (r_armed && w_tick) w_next = ST_SHIFT;
      end
      ST_HOLD: begin
        if (w_tick) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_div      <= '0;
      r_ss       <= '0;
      r_last     <= 1'b0;
      r_armed    <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_hcnt     <= '0;
    end else begin
      if (w_idle) begin
        r_sclk <= cpol;
      end else if (w_edge) begin
        r_sclk <= !r_sclk;
      end

      if (w_accept) begin
        r_last <= tx_last;
        r_rx   <= '0;
        if (w_idle) begin
          r_cpol <= cpol;
          r_cpha <= cpha;
          r_lsb  <= lsb_first;
          r_div  <= clk_div;
          r_ss   <= ss_sel;
        end
        // CPHA=0 presents the first bit before the first edge; CPHA=1 defers it.
        if (w_cpha) begin
          r_tx <= tx_data;
        end else begin
          r_mosi <= out_bit(tx_data, w_lsb);
          r_tx   <= shift_word(tx_data, w_lsb);
        end
      end

      if (w_accept && !w_idle) begin
        r_armed <= 1'b1;
      end else if (r_state == ST_SHIFT) begin
        r_armed <= 1'b0;
      end

      if (w_edge) begin
        r_hcnt <= w_last_half ? '0 : r_hcnt + 1'b1;
      end
      if (w_shift) begin
        r_mosi <= out_bit(r_tx, r_lsb);
        r_tx   <= shift_word(r_tx, r_lsb);
      end
      if (w_sample) begin
        r_rx <= w_rx_next;
      end

      if (w_done) begin
        r_rx_data  <= r_cpha ? w_rx_next : r_rx;
        r_rx_valid <= 1'b1;
      end else if (rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    ss_n = '1;
    if (!w_idle) begin
      for (int unsigned i = 0; i < NUM_SS; i++) begin
        if (r_ss == SSW'(i)) ss_n[i] = 1'b0;
      end
    end
  end

  assign busy     = !w_idle;
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_burst_master.sv
// Directed bench for spi_burst_master: loopback and a small mode-3 slave,
// with clk-domain monitors for sclk edges, half-periods and slave select.
module tb_spi_burst_master;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [7:0] clk_div = 8'd0;
  logic [1:0] ss_sel = 2'd0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_last = 1'b0, tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       busy, sclk, mosi, miso;
  logic [3:0] ss_n;

  int checks = 0;
  int errors = 0;

  logic       lb = 1'b1;
  logic       s_idle = 1'b1;
  logic [7:0] s_word = 8'h00;
  logic       s_miso = 1'b0;
  int         s_idx = 0;

  logic [3:0] ss_exp = 4'hF;
  logic       ss_mon = 1'b0;
  int         hp_gen = 0;

  int n_rise = 0, n_tog = 0, rx_pulses = 0, ss_low0 = 0, ss_bad = 0;
  int hp_min = 1000, hp_max = 0, hp_run = 0, hp_seen_gen = 0;
  logic hp_started = 1'b0, hp_prev = 1'b0, rxv_prev = 1'b0;

  always #5 clk = ~clk;

  assign miso = lb ? mosi : s_miso;

  spi_burst_master #(.DATA_WIDTH(8), .NUM_SS(4), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .clk_div(clk_div), .ss_sel(ss_sel), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy), .sclk(sclk),
    .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  // CPHA=1 slave on ss_n[0]: drives the next LSB-first bit on each leading edge.
  always @(sclk or ss_n[0]) begin
    if (ss_n[0] !== 1'b0) begin
      s_idx = 0;
    end else if (!lb && sclk !== s_idle) begin
      s_miso = s_word[s_idx[2:0]];
      s_idx++;
    end
  end

  always @(posedge sclk) n_rise++;
  always @(sclk) n_tog++;

  always @(posedge clk) begin
    if (ss_n[0] === 1'b0) ss_low0++;
    if (ss_mon && busy && ss_n !== ss_exp) ss_bad++;
    if (rx_valid && !rxv_prev) rx_pulses++;
    rxv_prev = rx_valid;
    if (hp_seen_gen != hp_gen) begin
      hp_seen_gen = hp_gen;
      hp_min = 1000; hp_max = 0; hp_started = 1'b0;
    end
    if (sclk !== hp_prev) begin
      if (hp_started) begin
        if (hp_run < hp_min) hp_min = hp_run;
        if (hp_run > hp_max) hp_max = hp_run;
      end
      hp_started = 1'b1;
      hp_run = 1;
    end else begin
      hp_run++;
    end
    hp_prev = sclk;
    if (rx_valid) hp_started = 1'b0;
  end

  task automatic set_cfg(input logic [1:0] mode, input logic lsb,
                         input logic [7:0] div, input logic [1:0] ss);
    @(negedge clk);
    {cpol, cpha} = mode; lsb_first = lsb; clk_div = div; ss_sel = ss;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] d, input logic last);
    int unsigned n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL send_timeout tx_ready=%b required 1", tx_ready);
    end
    tx_data = d; tx_last = last; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic wait_rx(output logic [7:0] d);
    int unsigned n = 0;
    while (rx_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++; $display("FAIL rx_timeout rx_valid=%b required 1", rx_valid);
    end
    d = rx_data;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_timeout busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ss_n !== 4'hF) begin errors++; $display("FAIL rst_ss_n got %b exp 1111", ss_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b exp 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b exp 0", mosi); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h exp 00", rx_data); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %b exp 1", tx_ready); end
  endtask

  task automatic test_mode0_loopback();
    logic [7:0] d;
    int low0, rise0;
    lb = 1'b1;
    set_cfg(SPI_MODE0, 1'b0, 8'd0, 2'd0);
    low0 = ss_low0; rise0 = n_rise;
    send_word(8'hA5, 1'b1);
    wait_rx(d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL m0_rx got %h exp a5", d); end
    wait_idle();
    checks++; if (ss_low0 - low0 !== 18) begin errors++; $display("FAIL m0_ss_low got %0d exp 18", ss_low0 - low0); end
    checks++; if (n_rise - rise0 !== 8) begin errors++; $display("FAIL m0_rises got %0d exp 8", n_rise - rise0); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL m0_sclk_idle got %b exp 0", sclk); end
  endtask

  task automatic test_mode3_lsb();
    logic [7:0] d;
    lb = 1'b0; s_idle = 1'b1; s_word = 8'h3C;
    set_cfg(SPI_MODE3, 1'b1, 8'd3, 2'd0);
    hp_gen++;
    send_word(8'h81, 1'b1);
    wait_rx(d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL m3_rx got %h exp 3c", d); end
    checks++; if (hp_min !== 4 || hp_max !== 4) begin
      errors++; $display("FAIL m3_half_period got min %0d max %0d exp 4", hp_min, hp_max);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL m3_sclk_idle got %b exp 1", sclk); end
    lb = 1'b1;
  endtask

  task automatic test_burst3();
    logic [7:0] d;
    logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
    int bad0, pulses0;
    set_cfg(SPI_MODE0, 1'b0, 8'd1, 2'd2);
    ss_exp = 4'b1011; ss_mon = 1'b1;
    bad0 = ss_bad; pulses0 = rx_pulses;
    for (int i = 0; i < 3; i++) begin
      send_word(words[i], i == 2);
      wait_rx(d);
      checks++; if (d !== words[i]) begin errors++; $display("FAIL burst_rx%0d got %h exp %h", i, d, words[i]); end
    end
    wait_idle();
    ss_mon = 1'b0;
    checks++; if (ss_bad - bad0 !== 0) begin errors++; $display("FAIL burst_ss_n bad cycles %0d exp 0", ss_bad - bad0); end
    checks++; if (rx_pulses - pulses0 !== 3) begin errors++; $display("FAIL burst_pulses got %0d exp 3", rx_pulses - pulses0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    int tog0, bad;
    int unsigned n = 0;
    set_cfg(SPI_MODE0, 1'b0, 8'd0, 2'd0);
    rx_ready = 1'b0;
    send_word(8'h5A, 1'b0);
    wait_rx(d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL bp_rx0 got %h exp 5a", d); end
    tx_data = 8'hC3; tx_last = 1'b1; tx_valid = 1'b1;
    tog0 = n_tog; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_ready !== 1'b0 || rx_valid !== 1'b1 || rx_data !== 8'h5A || busy !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stall bad cycles %0d exp 0", bad); end
    checks++; if (n_tog - tog0 !== 0) begin errors++; $display("FAIL bp_sclk_toggles got %0d exp 0", n_tog - tog0); end
    rx_ready = 1'b1;
    while (tx_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL bp_resume tx_ready=%b exp 1", tx_ready); end
    @(negedge clk);
    tx_valid = 1'b0; tx_last = 1'b0;
    wait_rx(d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL bp_rx1 got %h exp c3", d); end
    wait_idle();
  endtask

  task automatic test_reset_midburst();
    logic [7:0] d;
    int rise0;
    int unsigned n = 0;
    set_cfg(SPI_MODE0, 1'b0, 8'd1, 2'd0);
    rise0 = n_rise;
    send_word(8'hF0, 1'b1);
    while (n_rise - rise0 < 4 && n < 200) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    #1;
    checks++; if (ss_n !== 4'hF) begin errors++; $display("FAIL mid_rst_ss_n got %b exp 1111", ss_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL mid_rst_sclk got %b exp 0", sclk); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_rx_valid got %b exp 0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    send_word(8'h69, 1'b1);
    wait_rx(d);
    checks++; if (d !== 8'h69) begin errors++; $display("FAIL mid_rst_next_rx got %h exp 69", d); end
    wait_idle();
  endtask

  task automatic test_latched_cfg();
    logic [7:0] d;
    set_cfg(SPI_MODE0, 1'b0, 8'd1, 2'd0);
    hp_gen++;
    send_word(8'hC6, 1'b0);
    cpol = 1'b1; clk_div = 8'd5;
    wait_rx(d);
    checks++; if (d !== 8'hC6) begin errors++; $display("FAIL lat_rx0 got %h exp c6", d); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL lat_sclk_gap got %b exp 0", sclk); end
    send_word(8'h3B, 1'b1);
    wait_rx(d);
    checks++; if (d !== 8'h3B) begin errors++; $display("FAIL lat_rx1 got %h exp 3b", d); end
    checks++; if (hp_min !== 2 || hp_max !== 2) begin
      errors++; $display("FAIL lat_half_period got min %0d max %0d exp 2", hp_min, hp_max);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL lat_new_idle got %b exp 1", sclk); end
    hp_gen++;
    send_word(8'h96, 1'b1);
    wait_rx(d);
    checks++; if (d !== 8'h96) begin errors++; $display("FAIL lat_rx2 got %h exp 96", d); end
    checks++; if (hp_min !== 6 || hp_max !== 6) begin
      errors++; $display("FAIL lat_new_half_period got min %0d max %0d exp 6", hp_min, hp_max);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_mode3_lsb();
    test_burst3();
    test_backpressure();
    test_reset_midburst();
    test_latched_cfg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
